// File: rtl/aes_pkg.sv
// Shared AES ShiftRows definitions: legal column counts, per-row rotation offsets,
// byte/row/column index helpers, per-block mode encoding and the skid FSM states.
package aes_pkg;

   localparam bit SR_FWD = 1'b0;
   localparam bit SR_INV = 1'b1;

   typedef enum logic [1:0] {
      SR_EMPTY,
      SR_ONE,
      SR_TWO
   } srState_e;

   function automatic bit nb_legal(input int nb);
      return (nb == 4) || (nb == 6) || (nb == 8);
   endfunction

   // 256-bit Rijndael blocks spread the upper two rows further apart than 128/192-bit ones.
   function automatic int shift_offset(input int nb, input int row);
      if (nb == 8) begin
         if (row == 2) return 3;
         if (row == 3) return 4;
      end
      return row;
   endfunction

   function automatic int byte_idx(input int row, input int col);
      return 4 * col + row;
   endfunction

   function automatic int row_of(input int k);
      return k % 4;
   endfunction

   function automatic int col_of(input int k);
      return k / 4;
   endfunction

endpackage

// File: rtl/aes_shiftrows_pipe_if.sv
// Handshake bundle for the ShiftRows stage: upstream block/tag/mode and downstream result.
// The stage itself connects through the slave modport, its environment through master.
interface aes_shiftrows_pipe_if #(
   parameter int NB    = 4,
   parameter int TAG_W = 4
);
   logic               in_valid;
   logic               in_ready;
   logic               in_inv;
   logic [TAG_W-1:0]   in_tag;
   logic [0:32*NB-1]   in_state;
   logic               out_valid;
   logic               out_ready;
   logic [TAG_W-1:0]   out_tag;
   logic [0:32*NB-1]   out_state;

   modport master (
      output in_valid, in_inv, in_tag, in_state, out_ready,
      input  in_ready, out_valid, out_tag, out_state
   );

   modport slave (
      input  in_valid, in_inv, in_tag, in_state, out_ready,
      output in_ready, out_valid, out_tag, out_state
   );
endinterface

// File: rtl/aes_sr_permute.sv
// Combinational ShiftRows byte permutation for NB columns.
// AES_SR_FWD_EN adds the forward rotation selected by inv_i; otherwise every block is inverse.
module aes_sr_permute
   import aes_pkg::*;
#(
   parameter int NB = 4
) (
   input  logic [0:32*NB-1] state_i,
   input  logic             inv_i,
   output logic [0:32*NB-1] state_o
);

   logic [0:32*NB-1] invState;
`ifdef AES_SR_FWD_EN
   logic [0:32*NB-1] fwdState;
`endif

   // Each output byte is pure wiring from one input byte of the same row.
   for (genvar k = 0; k < 4 * NB; k++) begin : g_byte
      localparam int R       = row_of(k);
      localparam int C       = col_of(k);
      localparam int S       = shift_offset(NB, R);
      localparam int INV_SRC = byte_idx(R, (C - S + NB) % NB);
      assign invState[8*k +: 8] = state_i[8*INV_SRC +: 8];
`ifdef AES_SR_FWD_EN
      localparam int FWD_SRC = byte_idx(R, (C + S) % NB);
      assign fwdState[8*k +: 8] = state_i[8*FWD_SRC +: 8];
`endif
   end

`ifdef AES_SR_FWD_EN
   assign state_o = (inv_i == SR_INV) ? invState : fwdState;
`else
   logic unusedInv;
   assign unusedInv = inv_i;
   assign state_o   = invState;
`endif

endmodule

// File: rtl/aes_shiftrows_pipe.sv
// Handshaked ShiftRows stage: input-side permutation, one output register plus a skid register.
// Define AES_SR_FWD_EN to build the forward path as well; default is inverse-only.
module aes_shiftrows_pipe
   import aes_pkg::*;
#(
   parameter int NB    = 4,
   parameter int TAG_W = 4
) (
   input logic                 clk,
   input logic                 rst,
   aes_shiftrows_pipe_if.slave bus
);

   if (!nb_legal(NB)) begin : g_badNb
      $error("aes_shiftrows_pipe: NB must be 4, 6 or 8");
   end
   if (TAG_W < 1) begin : g_badTag
      $error("aes_shiftrows_pipe: TAG_W must be at least 1");
   end

   srState_e         state_q, state_d;
   logic [0:32*NB-1] mainState_q, mainState_d, skidState_q, skidState_d;
   logic [TAG_W-1:0] mainTag_q, mainTag_d, skidTag_q, skidTag_d;
   logic [0:32*NB-1] permState;
   logic             inReady, outValid, accept, drain;
   logic             loadNew, loadSkid, moveSkid;

   aes_sr_permute #(.NB(NB)) u_permute (
      .state_i (bus.in_state),
      .inv_i   (bus.in_inv),
      .state_o (permState)
   );

   // Ready depends only on the state register, so out_ready never reaches in_ready.
   assign inReady       = (state_q != SR_TWO);
   assign outValid      = (state_q != SR_EMPTY);
   assign accept        = bus.in_valid && inReady;
   assign drain         = outValid && bus.out_ready;
   assign bus.in_ready  = inReady;
   assign bus.out_valid = outValid;
   assign bus.out_state = mainState_q;
   assign bus.out_tag   = mainTag_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= SR_EMPTY;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         SR_EMPTY: if (accept) state_d = SR_ONE;
         SR_ONE: begin
            if (accept && !drain)      state_d = SR_TWO;
            else if (!accept && drain) state_d = SR_EMPTY;
         end
         SR_TWO:   if (drain) state_d = SR_ONE;
         default:  state_d = SR_EMPTY;
      endcase
   end

   // A new block goes straight to main unless main is still waiting on the consumer.
   always_comb begin
      loadNew  = 1'b0;
      loadSkid = 1'b0;
      moveSkid = 1'b0;
      case (state_q)
         SR_EMPTY: loadNew = accept;
         SR_ONE: begin
            loadNew  = accept && drain;
            loadSkid = accept && !drain;
         end
         SR_TWO:   moveSkid = drain;
         default:  ;
      endcase
   end

   always_comb begin
      mainState_d = mainState_q;
      mainTag_d   = mainTag_q;
      skidState_d = skidState_q;
      skidTag_d   = skidTag_q;
      if (loadNew) begin
         mainState_d = permState;
         mainTag_d   = bus.in_tag;
      end else if (moveSkid) begin
         mainState_d = skidState_q;
         mainTag_d   = skidTag_q;
      end
      if (loadSkid) begin
         skidState_d = permState;
         skidTag_d   = bus.in_tag;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mainState_q <= '0;
         mainTag_q   <= '0;
         skidState_q <= '0;
         skidTag_q   <= '0;
      end else begin
         mainState_q <= mainState_d;
         mainTag_q   <= mainTag_d;
         skidState_q <= skidState_d;
         skidTag_q   <= skidTag_d;
      end
   end

endmodule
